switch_input_port: RTL and testbench



---
 rtl/switch_input_port.sv | 151 +++++++++++++++
 tb/tb_switch_input_port.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/switch_input_port.sv
// Buffered switch input port: synchronizes switches and the confirm button, pushes a
// switch snapshot per confirmed press into a FIFO drained by IORead. Macro: SWPORT_DEBOUNCE_EN.
module switch_input_port #(
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [SW_WIDTH-1:0] switches,
  input  logic                confirm_bt,
  input  logic                ior,
  input  logic                switchctrl,
  input  logic [1:0]          ioaddr,
  output logic [15:0]         ioread_data,
  output logic                data_valid,
  output logic                overrun
);
  localparam int AW = $clog2(FIFO_DEPTH);

  if (SW_WIDTH > 16 || DEBOUNCE_CYCLES < 1 || FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_param_chk
    $error("switch_input_port: bad parameters");
  end

  logic [1:0]          btn_sync;
  logic [SW_WIDTH-1:0] sw_meta, sw_s;
  logic                btn_s, press;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_sync <= '0;
      sw_meta  <= '0;
      sw_s     <= '0;
    end else begin
      btn_sync <= {btn_sync[0], confirm_bt};
      sw_meta  <= switches;
      sw_s     <= sw_meta;
    end
  end
  assign btn_s = btn_sync[1];

`ifdef SWPORT_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW} db_state_t;

  db_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;

  assign cnt_inc = cnt + CW'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= LOW;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // press is a Mealy output: asserted in the cycle whose closing edge enters HIGH
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    press     = 1'b0;
    case (state)
      LOW:
        if (btn_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nxt = HIGH;
            press     = 1'b1;
          end else begin
            state_nxt = WAIT_HIGH;
            cnt_nxt   = CW'(1);
          end
        end
      WAIT_HIGH:
        if (!btn_s) state_nxt = LOW;
        else if (cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
          state_nxt = HIGH;
          press     = 1'b1;
        end else cnt_nxt = cnt_inc;
      HIGH:
        if (!btn_s) begin
          if (DEBOUNCE_CYCLES == 1) state_nxt = LOW;
          else begin
            state_nxt = WAIT_LOW;
            cnt_nxt   = CW'(1);
          end
        end
      WAIT_LOW:
        if (btn_s) state_nxt = HIGH;
        else if (cnt_inc == CW'(DEBOUNCE_CYCLES)) state_nxt = LOW;
        else cnt_nxt = cnt_inc;
      default: state_nxt = LOW;
    endcase
  end
`else
  logic btn_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) btn_q <= 1'b0;
    else       btn_q <= btn_s;
  end
  assign press = btn_s & ~btn_q;
`endif

  logic [FIFO_DEPTH-1:0][15:0] mem;
  logic [AW:0]                 rd_ptr, wr_ptr, count;
  logic                        sel, empty, full, pop, push, drop, status_rd;

  assign sel       = ior & switchctrl;
  assign empty     = (rd_ptr == wr_ptr);
  assign full      = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
  assign count     = wr_ptr - rd_ptr;
  assign pop       = sel && (ioaddr == 2'b00) && !empty;
  assign status_rd = sel && (ioaddr == 2'b01);
  // a pop in the same cycle frees the slot the push needs
  assign push      = press && (!full || pop);
  assign drop      = press && full && !pop;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= 16'(sw_s);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (drop)           overrun <= 1'b1;
      else if (status_rd) overrun <= 1'b0;
    end
  end

  assign data_valid = !empty;

  always_comb begin
    ioread_data = '0;
    if (sel) begin
      case (ioaddr)
        2'b00:   if (!empty) ioread_data = mem[rd_ptr[AW-1:0]];
        2'b01:   ioread_data = {10'b0, 3'(count), overrun, full, !empty};
        default: ioread_data = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_switch_input_port.sv
// Directed bench for switch_input_port (DEBOUNCE_CYCLES=4); expectations follow the
// SWPORT_DEBOUNCE_EN setting of the build.
module tb_switch_input_port;
  localparam int DB = 4;
`ifdef SWPORT_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
  localparam int PUSH = 2 + DB;
`else
  localparam bit DEB = 1'b0;
  localparam int PUSH = 3;
`endif

  logic        clock = 1'b0, reset = 1'b1;
  logic [15:0] switches = '0;
  logic        confirm_bt = 1'b0, ior = 1'b0, switchctrl = 1'b0;
  logic [1:0]  ioaddr = '0;
  logic [15:0] ioread_data;
  logic        data_valid, overrun;
  int          checks = 0, errors = 0;

  switch_input_port #(.SW_WIDTH(16), .DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .switches(switches), .confirm_bt(confirm_bt),
    .ior(ior), .switchctrl(switchctrl), .ioaddr(ioaddr),
    .ioread_data(ioread_data), .data_valid(data_valid), .overrun(overrun));

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        ior, sel;
    logic [1:0]  addr;
    logic [15:0] rdata;
    logic        valid, ovr;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    ior = 1'b1; switchctrl = 1'b1; ioaddr = a;
    #1 d = ioread_data;
    step();
    ior = 1'b0; switchctrl = 1'b0; ioaddr = 2'b00;
  endtask

  task automatic press_btn(input logic [15:0] v);
    switches = v; confirm_bt = 1'b1;
    step(10);
    confirm_bt = 1'b0;
    step(10);
  endtask

  logic [15:0] d;

  initial begin
    vecs[0]  = '{"idle",      1'b0, 1'b1, 2'b00, 16'h0000, 1'b1, 1'b1};
    vecs[1]  = '{"nosel",     1'b1, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b1};
    vecs[2]  = '{"addr2",     1'b1, 1'b1, 2'b10, 16'h0000, 1'b1, 1'b1};
    vecs[3]  = '{"addr3",     1'b1, 1'b1, 2'b11, 16'h0000, 1'b1, 1'b1};
    vecs[4]  = '{"stat_full", 1'b1, 1'b1, 2'b01, 16'h0027, 1'b1, 1'b1};
    vecs[5]  = '{"stat_clr",  1'b1, 1'b1, 2'b01, 16'h0023, 1'b1, 1'b0};
    vecs[6]  = '{"pop1",      1'b1, 1'b1, 2'b00, 16'h0001, 1'b1, 1'b0};
    vecs[7]  = '{"pop2",      1'b1, 1'b1, 2'b00, 16'h0002, 1'b1, 1'b0};
    vecs[8]  = '{"stat_cnt2", 1'b1, 1'b1, 2'b01, 16'h0011, 1'b1, 1'b0};
    vecs[9]  = '{"pop3",      1'b1, 1'b1, 2'b00, 16'h0003, 1'b1, 1'b0};
    vecs[10] = '{"pop4",      1'b1, 1'b1, 2'b00, 16'h0004, 1'b1, 1'b0};
    vecs[11] = '{"stat_empty",1'b1, 1'b1, 2'b01, 16'h0000, 1'b0, 1'b0};
    vecs[12] = '{"pop_empty", 1'b1, 1'b1, 2'b00, 16'h0000, 1'b0, 1'b0};

    // reset state
    #12;
    chk("rst_rdata", ioread_data, 16'h0);
    chk("rst_valid", {15'b0, data_valid}, 16'h0);
    chk("rst_ovr", {15'b0, overrun}, 16'h0);
    @(negedge clock) reset = 1'b0;

    // single press: push exactly at edge PUSH
    switches = 16'hA5C3; confirm_bt = 1'b1;
    for (int e = 1; e <= PUSH; e++) begin
      step();
      chk($sformatf("lat_e%0d", e), {15'b0, data_valid}, {15'b0, e >= PUSH});
    end
    step(10 - PUSH);
    confirm_bt = 1'b0;
    step(10);
    rd(2'b01, d); chk("hold_one_push", d, 16'h0009);
    rd(2'b00, d); chk("read_a5c3", d, 16'hA5C3);
    chk("valid_after_pop", {15'b0, data_valid}, 16'h0);
    rd(2'b00, d); chk("read_empty", d, 16'h0);

    // short pulses: filtered by debounce, each rising edge pushes otherwise
    switches = 16'h0BEE;
    foreach (vecs[i]) ; // keep table intact
    for (int i = 0; i < 5; i++) begin
      confirm_bt = (i == 0 || i == 2 || i == 3);
      step();
    end
    confirm_bt = 1'b0;
    step(10);
    rd(2'b01, d); chk("bounce", d, DEB ? 16'h0000 : 16'h0011);
    rd(2'b00, d); rd(2'b00, d);

    // hold, short release glitch, hold again
    confirm_bt = 1'b1; step(8);
    confirm_bt = 1'b0; step(2);
    confirm_bt = 1'b1; step(20);
    rd(2'b01, d); chk("glitch_release", d, DEB ? 16'h0009 : 16'h0011);
    confirm_bt = 1'b0; step(10);
    confirm_bt = 1'b1; step(10);
    confirm_bt = 1'b0; step(10);
    rd(2'b01, d); chk("repress", d, DEB ? 16'h0011 : 16'h0019);
    for (int i = 0; i < 3; i++) rd(2'b00, d);
    chk("drained", {15'b0, data_valid}, 16'h0);

    // fill and overrun, then table-driven reads
    for (int v = 1; v <= 5; v++) press_btn(16'(v));
    for (int i = 0; i < 13; i++) begin
      ior = vecs[i].ior; switchctrl = vecs[i].sel; ioaddr = vecs[i].addr;
      #1;
      chk({vecs[i].name, "_rdata"}, ioread_data, vecs[i].rdata);
      chk({vecs[i].name, "_valid"}, {15'b0, data_valid}, {15'b0, vecs[i].valid});
      chk({vecs[i].name, "_ovr"}, {15'b0, overrun}, {15'b0, vecs[i].ovr});
      step();
    end
    ior = 1'b0; switchctrl = 1'b0; ioaddr = 2'b00;

    // full FIFO: pop coincides with the 5th push
    press_btn(16'h0011); press_btn(16'h0022); press_btn(16'h0033); press_btn(16'h0044);
    switches = 16'h0055; confirm_bt = 1'b1;
    step(PUSH - 1);
    ior = 1'b1; switchctrl = 1'b1; ioaddr = 2'b00;
    #1 chk("simul_head", ioread_data, 16'h0011);
    step();
    ior = 1'b0; switchctrl = 1'b0;
    confirm_bt = 1'b0;
    chk("simul_ovr", {15'b0, overrun}, 16'h0);
    rd(2'b01, d); chk("simul_stat", d, 16'h0023);
    step(10);
    rd(2'b00, d); chk("simul_d2", d, 16'h0022);
    rd(2'b00, d); chk("simul_d3", d, 16'h0033);
    rd(2'b00, d); chk("simul_d4", d, 16'h0044);
    rd(2'b00, d); chk("simul_d5", d, 16'h0055);

    // async reset mid-operation
    press_btn(16'h0077); press_btn(16'h0088);
    switches = 16'h0099; confirm_bt = 1'b1;
    step(3);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", {15'b0, data_valid}, 16'h0);
    chk("mid_rst_ovr", {15'b0, overrun}, 16'h0);
    ior = 1'b1; switchctrl = 1'b1; ioaddr = 2'b01;
    #1 chk("mid_rst_stat", ioread_data, 16'h0);
    ior = 1'b0; switchctrl = 1'b0; ioaddr = 2'b00;
    @(negedge clock) reset = 1'b0;
    for (int e = 1; e <= PUSH; e++) begin
      step();
      chk($sformatf("rst_lat_e%0d", e), {15'b0, data_valid}, {15'b0, e >= PUSH});
    end
    confirm_bt = 1'b0;
    rd(2'b00, d); chk("rst_snapshot", d, 16'h0099);
    rd(2'b01, d); chk("rst_final_stat", d, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
